avalon_frame_readback_checker: RTL and testbench
================================================

Name: avalon_frame_readback_checker

Overview:
- Downstream consumer of the DDR frame-fill writer. When the writer reports its fill complete, this block reads the whole frame back over Avalon-MM with pipelined read bursts.
- Each returned word is checked against the fill pattern, which is data = word address, zero-extended to DATA_W.
- Reports done, pass/fail, an error count and the first failing address to the status/LED logic.

Parameters:
ADDR_W, 27, Avalon word address width
DATA_W, 32, Avalon data width
BURST_LEN, 8, words per read burst (≥1)
BURST_W, 4, avl_burstcount width (must hold BURST_LEN)
FRAME_WORDS, 2073600, words checked (1920*1080), starting at address 0
MAX_OUTST, 4, maximum outstanding bursts

Ports:
iCLK  in  1  clock
iRST_n  in  1  reset; synchronous, active-low
iSTART  in  1  start level, driven from the writer's test-complete flag; acts on its rising edge
local_init_done  in  1  DDR controller calibrated
avl_waitrequest_n  in  1  command accepted when high with avl_read=1
avl_address  out  ADDR_W  burst start word address
avl_read  out  1  read request
avl_burstcount  out  BURST_W  words in this burst
avl_burstbegin  out  1  first presentation cycle of each command
avl_readdata  in  DATA_W  read data
avl_readdatavalid  in  1  readdata valid
oDONE  out  1  frame check finished
oPASS  out  1  oDONE and zero errors
oERR_COUNT  out  16  mismatch count, saturates at 16'hFFFF
oFIRST_ERR_ADDR  out  ADDR_W  address of the first mismatch
c_state  out  3  FSM state, debug

Behaviour:
- Reset values: all outputs 0. Internal counters are 0. start_d resets to 1, so an iSTART held high through reset does not trigger a start.
- start_pulse = iSTART & ~start_d, with start_d registered every cycle.
- State IDLE (0):
  - avl_read=0.
  - On start_pulse && local_init_done: clear req_addr, rx_addr, outstanding count, error outputs and oDONE, then go to ISSUE.
  - A start_pulse while local_init_done=0 is dropped.
- State ISSUE (1):
  - Issue condition: a new command may issue when outstanding words + BURST_LEN ≤ MAX_OUTST*BURST_LEN.
  - When a command issues:
    - avl_read=1, avl_address=req_addr.
    - avl_burstcount = min(BURST_LEN, FRAME_WORDS - req_addr).
    - avl_burstbegin=1 for the first cycle only.
  - While avl_waitrequest_n=0: address, burstcount and read are held stable, and burstbegin stays 0.
  - On acceptance (avl_read & avl_waitrequest_n):
    - req_addr += burstcount; outstanding += burstcount.
    - If req_addr reaches FRAME_WORDS, go to DRAIN, dropping avl_read in the next cycle.
    - Otherwise the next command may be presented in the very next cycle, with a new burstbegin pulse.
  - If the outstanding limit is hit, avl_read=0 until the issue condition holds again.
- Every avl_readdatavalid cycle in ISSUE or DRAIN:
  - Compare avl_readdata with {zero-extend rx_addr}.
  - rx_addr += 1; outstanding -= 1. Acceptance and data return in the same cycle both apply, giving a net change.
  - The mismatch flag is registered, 1-cycle compare latency. In the next cycle:
    - oERR_COUNT increments (saturating).
    - If oERR_COUNT was 0, oFIRST_ERR_ADDR takes the failing address.
- State DRAIN (2): wait until rx_addr == FRAME_WORDS and the compare pipeline is empty, then go to DONE.
- State DONE (3):
  - oDONE=1; oPASS=(oERR_COUNT==0). The error outputs hold.
  - start_pulse && local_init_done restarts the check: clear, go to ISSUE.
- Unused encodings go to IDLE.
- avl_readdatavalid in IDLE or DONE is ignored: no counting, no compare.
- Reset mid-operation: everything returns to its reset value. Late returning data is ignored by the IDLE rule.
- Width rules:
  - req_addr and rx_addr are ADDR_W bits; FRAME_WORDS must be ≤ 2^ADDR_W.
  - The outstanding counter must hold MAX_OUTST*BURST_LEN.
- Completion: after the final burst is accepted, oDONE rises 2 cycles after the last readdatavalid.

Test Plan:
- Ideal memory (data=addr, waitrequest_n=1, read latency 6), start pulse -> exactly 259200 commands, each with burstcount=8 and address stepping by 8; oDONE=1, oPASS=1, oERR_COUNT=0.
- Memory corrupts addr 0x1000 (data^1) and addr 0x2000 -> oERR_COUNT=2, oFIRST_ERR_ADDR=0x1000, oPASS=0 at oDONE.
- waitrequest_n randomly low 50% of cycles -> address, burstcount and read stable while low; exactly one burstbegin per command; result oPASS=1.
- Memory withholds readdatavalid for 200 cycles -> avl_read drops after 4 accepted bursts (32 words outstanding), resumes as data returns; final oPASS=1.
- FRAME_WORDS=20, BURST_LEN=8 -> burstcounts 8,8,4; oDONE after 20 words. iSTART high while local_init_done=0 -> stays IDLE. iSTART high through reset -> no start.
- Reset asserted mid-DRAIN with 16 words outstanding -> all outputs 0 and late readdatavalid ignored; a new start then yields oPASS=1, oERR_COUNT=0.

Source files
------------

// File: rtl/avalon_frame_readback_checker_if.sv
// Avalon-MM read channel between the frame read-back checker (master) and
// the DDR controller local interface (slave).
interface avalon_frame_readback_checker_if #(
    parameter int ADDR_W  = 27,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 4
);
    logic [ADDR_W-1:0]  avl_address;
    logic               avl_read;
    logic [BURST_W-1:0] avl_burstcount;
    logic               avl_burstbegin;
    logic               avl_waitrequest_n;
    logic [DATA_W-1:0]  avl_readdata;
    logic               avl_readdatavalid;

    modport master (
        output avl_address,
        output avl_read,
        output avl_burstcount,
        output avl_burstbegin,
        input  avl_waitrequest_n,
        input  avl_readdata,
        input  avl_readdatavalid
    );

    modport slave (
        input  avl_address,
        input  avl_read,
        input  avl_burstcount,
        input  avl_burstbegin,
        output avl_waitrequest_n,
        output avl_readdata,
        output avl_readdatavalid
    );
endinterface

// File: rtl/avalon_frame_readback_checker.sv
// Reads a filled frame back over Avalon-MM with pipelined bursts and checks
// every word against the fill pattern data == word address.
module avalon_frame_readback_checker #(
    parameter int ADDR_W      = 27,
    parameter int DATA_W      = 32,
    parameter int BURST_LEN   = 8,
    parameter int BURST_W     = 4,
    parameter int FRAME_WORDS = 2073600,
    parameter int MAX_OUTST   = 4
) (
    input  logic                  iCLK,
    input  logic                  iRST_n,
    input  logic                  iSTART,
    input  logic                  local_init_done,
    avalon_frame_readback_checker_if.master avl,
    output logic                  oDONE,
    output logic                  oPASS,
    output logic [15:0]           oERR_COUNT,
    output logic [ADDR_W-1:0]     oFIRST_ERR_ADDR,
    output logic [2:0]            c_state
);

    localparam int LIMIT = MAX_OUTST * BURST_LEN;
    localparam int OUT_W = $clog2(LIMIT + 1);

    // Address counters carry one extra bit so FRAME_WORDS == 2^ADDR_W is reachable.
    localparam logic [ADDR_W:0] FW_C  = (ADDR_W + 1)'(FRAME_WORDS);
    localparam logic [ADDR_W:0] BL_A  = (ADDR_W + 1)'(BURST_LEN);
    localparam logic [OUT_W:0]  BL_O  = (OUT_W + 1)'(BURST_LEN);
    localparam logic [OUT_W:0]  LIM_O = (OUT_W + 1)'(LIMIT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3
    } state_t;

    state_t              state_q, state_d;
    logic                start_dly_q;
    logic [ADDR_W:0]     req_addr_q, req_addr_d;
    logic [ADDR_W:0]     rx_addr_q, rx_addr_d;
    logic [OUT_W-1:0]    outst_q, outst_d;
    logic                read_q, read_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BURST_W-1:0]  bcnt_q, bcnt_d;
    logic                bbegin_q, bbegin_d;
    logic                mis_q, mis_d;
    logic [ADDR_W-1:0]   mis_addr_q, mis_addr_d;
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]   first_err_q, first_err_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;

    logic                start_pulse_s;
    logic                active_s;
    logic                rv_s;
    logic                accept_s;
    logic                restart_s;
    logic [ADDR_W:0]     req_next_s;
    logic [OUT_W-1:0]    outst_next_s;

    function automatic logic [BURST_W-1:0] burst_for(input logic [ADDR_W:0] addr);
        logic [ADDR_W:0] remaining;
        remaining = FW_C - addr;
        return (remaining < BL_A) ? BURST_W'(remaining) : BURST_W'(BURST_LEN);
    endfunction

    function automatic logic room_for_burst(input logic [OUT_W-1:0] outst);
        return ({1'b0, outst} + BL_O) <= LIM_O;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    // Next-state, command generation and read-data compare.
    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        rx_addr_d   = rx_addr_q;
        outst_d     = outst_q;
        read_d      = read_q;
        addr_d      = addr_q;
        bcnt_d      = bcnt_q;
        bbegin_d    = 1'b0;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        done_d      = done_q;
        pass_d      = pass_q;
        restart_s   = 1'b0;

        start_pulse_s = iSTART & ~start_dly_q;
        active_s      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        rv_s          = avl.avl_readdatavalid & active_s;
        accept_s      = read_q & avl.avl_waitrequest_n;
        req_next_s    = req_addr_q + (accept_s ? (ADDR_W + 1)'(bcnt_q) : {(ADDR_W + 1){1'b0}});
        outst_next_s  = outst_q + (accept_s ? OUT_W'(bcnt_q) : {OUT_W{1'b0}}) - OUT_W'(rv_s);

        mis_d      = rv_s && (avl.avl_readdata != DATA_W'(rx_addr_q[ADDR_W-1:0]));
        mis_addr_d = rx_addr_q[ADDR_W-1:0];

        // The compare result of the previous cycle lands in the error outputs now.
        if (mis_q) begin
            err_cnt_d = sat_inc(err_cnt_q);
            if (err_cnt_q == 16'd0) begin
                first_err_d = mis_addr_q;
            end else begin
                first_err_d = first_err_q;
            end
        end else begin
            err_cnt_d = err_cnt_q;
        end

        case (state_q)
            S_IDLE: begin
                read_d    = 1'b0;
                restart_s = start_pulse_s & local_init_done;
            end
            S_ISSUE: begin
                req_addr_d = req_next_s;
                if (read_q && !avl.avl_waitrequest_n) begin
                    read_d = 1'b1;
                end else if (accept_s && (req_next_s == FW_C)) begin
                    read_d  = 1'b0;
                    state_d = S_DRAIN;
                end else if ((req_next_s < FW_C) && room_for_burst(outst_next_s)) begin
                    read_d   = 1'b1;
                    addr_d   = req_next_s[ADDR_W-1:0];
                    bcnt_d   = burst_for(req_next_s);
                    bbegin_d = 1'b1;
                end else begin
                    read_d = 1'b0;
                end
            end
            S_DRAIN: begin
                read_d = 1'b0;
                // The last word's compare commits on the same edge we leave DRAIN.
                if (rx_addr_q == FW_C) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == 16'd0);
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                read_d    = 1'b0;
                done_d    = 1'b1;
                restart_s = start_pulse_s & local_init_done;
            end
            default: begin
                read_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        if (restart_s) begin
            state_d     = S_ISSUE;
            req_addr_d  = {(ADDR_W + 1){1'b0}};
            rx_addr_d   = {(ADDR_W + 1){1'b0}};
            outst_d     = {OUT_W{1'b0}};
            err_cnt_d   = 16'd0;
            first_err_d = {ADDR_W{1'b0}};
            done_d      = 1'b0;
            pass_d      = 1'b0;
            mis_d       = 1'b0;
        end else begin
            rx_addr_d = rx_addr_q + (ADDR_W + 1)'(rv_s);
            outst_d   = outst_next_s;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state_q     <= S_IDLE;
            start_dly_q <= 1'b1;
            req_addr_q  <= {(ADDR_W + 1){1'b0}};
            rx_addr_q   <= {(ADDR_W + 1){1'b0}};
            outst_q     <= {OUT_W{1'b0}};
            read_q      <= 1'b0;
            addr_q      <= {ADDR_W{1'b0}};
            bcnt_q      <= {BURST_W{1'b0}};
            bbegin_q    <= 1'b0;
            mis_q       <= 1'b0;
            mis_addr_q  <= {ADDR_W{1'b0}};
            err_cnt_q   <= 16'd0;
            first_err_q <= {ADDR_W{1'b0}};
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_dly_q <= iSTART;
            req_addr_q  <= req_addr_d;
            rx_addr_q   <= rx_addr_d;
            outst_q     <= outst_d;
            read_q      <= read_d;
            addr_q      <= addr_d;
            bcnt_q      <= bcnt_d;
            bbegin_q    <= bbegin_d;
            mis_q       <= mis_d;
            mis_addr_q  <= mis_addr_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign avl.avl_read       = read_q;
    assign avl.avl_address    = addr_q;
    assign avl.avl_burstcount = bcnt_q;
    assign avl.avl_burstbegin = bbegin_q;

    assign oDONE           = done_q;
    assign oPASS           = pass_q;
    assign oERR_COUNT      = err_cnt_q;
    assign oFIRST_ERR_ADDR = first_err_q;
    assign c_state         = state_q;

endmodule

// File: tb/tb_avalon_frame_readback_checker.sv
// Bench for the frame read-back checker: a behavioural Avalon memory serves two
// instances (a large frame and a 20-word frame), one active at a time.
module tb_avalon_frame_readback_checker;

    localparam int AW = 27, DW = 32, BL = 8, BW = 4, MO = 4;
    localparam int FW_A = 8200, FW_B = 20;

    logic clk, rst_n, start_a, start_b, init_done;
    logic waitn, rv;
    logic [DW-1:0] rdata;

    avalon_frame_readback_checker_if #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) bus_a ();
    avalon_frame_readback_checker_if #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) bus_b ();

    assign bus_a.avl_waitrequest_n = waitn;
    assign bus_a.avl_readdata      = rdata;
    assign bus_a.avl_readdatavalid = rv;
    assign bus_b.avl_waitrequest_n = waitn;
    assign bus_b.avl_readdata      = rdata;
    assign bus_b.avl_readdatavalid = rv;

    logic done_a, pass_a, done_b, pass_b;
    logic [15:0] err_a, err_b;
    logic [AW-1:0] first_a, first_b;
    logic [2:0] state_a, state_b;

    avalon_frame_readback_checker #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .BURST_W(BW),
        .FRAME_WORDS(FW_A), .MAX_OUTST(MO)) dut_a (
        .iCLK(clk), .iRST_n(rst_n), .iSTART(start_a), .local_init_done(init_done), .avl(bus_a),
        .oDONE(done_a), .oPASS(pass_a), .oERR_COUNT(err_a), .oFIRST_ERR_ADDR(first_a), .c_state(state_a));

    avalon_frame_readback_checker #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .BURST_W(BW),
        .FRAME_WORDS(FW_B), .MAX_OUTST(MO)) dut_b (
        .iCLK(clk), .iRST_n(rst_n), .iSTART(start_b), .local_init_done(init_done), .avl(bus_b),
        .oDONE(done_b), .oPASS(pass_b), .oERR_COUNT(err_b), .oFIRST_ERR_ADDR(first_b), .c_state(state_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory agent controls and statistics
    bit sel, rand_wait, hold, flush;
    int lat, gap_pct, cyc;
    int cmd_cnt, bb_cnt, proto_err, bad_cmd, words_acc, words_ret, max_outst;
    int last_rv_cyc, done_cyc, exp_addr;
    int unsigned cmd_addr[$];
    int cmd_bc[$];
    int unsigned corr_addr[$];
    logic [DW-1:0] corr_mask[$];
    typedef struct { int unsigned addr; int rdy; } word_t;
    word_t pend[$];
    bit prev_stall;
    logic [AW-1:0] prev_addr;
    logic [BW-1:0] prev_bc;
    int n_cmp, n_bad;

    wire          o_read = sel ? bus_b.avl_read : bus_a.avl_read;
    wire [AW-1:0] o_addr = sel ? bus_b.avl_address : bus_a.avl_address;
    wire [BW-1:0] o_bc   = sel ? bus_b.avl_burstcount : bus_a.avl_burstcount;
    wire          o_bb   = sel ? bus_b.avl_burstbegin : bus_a.avl_burstbegin;
    wire          o_done = sel ? done_b : done_a;

    function automatic logic [DW-1:0] mem_data(input int unsigned a);
        logic [DW-1:0] d;
        d = DW'(a);
        foreach (corr_addr[i]) if (corr_addr[i] == a) d = d ^ corr_mask[i];
        return d;
    endfunction

    // Behavioural memory: acts at negedge on what the next posedge will sample.
    initial begin
        waitn = 1'b1; rv = 1'b0; rdata = '0; cyc = 0; prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (flush) pend.delete();
            waitn = rand_wait ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (prev_stall && (!o_read || o_addr !== prev_addr || o_bc !== prev_bc || o_bb !== 1'b0))
                proto_err++;
            if (o_bb && !o_read) proto_err++;
            if (o_bb && o_read) bb_cnt++;
            prev_stall = o_read && !waitn && rst_n;
            prev_addr = o_addr;
            prev_bc = o_bc;
            if (o_read && waitn && rst_n) begin
                int fw, want;
                fw = sel ? FW_B : FW_A;
                want = (fw - exp_addr < BL) ? fw - exp_addr : BL;
                if (int'(o_addr) != exp_addr || int'(o_bc) != want) bad_cmd++;
                cmd_addr.push_back(int'(o_addr));
                cmd_bc.push_back(int'(o_bc));
                cmd_cnt++;
                exp_addr += int'(o_bc);
                for (int i = 0; i < int'(o_bc); i++) pend.push_back('{int'(o_addr) + i, cyc + lat});
                words_acc += int'(o_bc);
            end
            if (!hold && pend.size() > 0 && pend[0].rdy <= cyc && $urandom_range(0, 99) >= gap_pct) begin
                rv = 1'b1;
                rdata = mem_data(pend[0].addr);
                void'(pend.pop_front());
                words_ret++;
                last_rv_cyc = cyc;
            end else begin
                rv = 1'b0;
                rdata = $urandom;
            end
            if (words_acc - words_ret > max_outst) max_outst = words_acc - words_ret;
            if (o_done && done_cyc < 0) done_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_stats();
        flush = 1'b1; tick(1); flush = 1'b0;
        cmd_cnt = 0; bb_cnt = 0; proto_err = 0; bad_cmd = 0; words_acc = 0; words_ret = 0;
        max_outst = 0; last_rv_cyc = 0; done_cyc = -1; exp_addr = 0;
        cmd_addr.delete(); cmd_bc.delete();
    endtask

    task automatic pulse_start(input bit b);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        tick(1);
        start_a = 1'b0; start_b = 1'b0;
        done_cyc = -1;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int i;
        for (i = 0; i < budget && !o_done; i++) tick(1);
        if (!o_done) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: oDONE=0 after %0d cycles, required 1", nm, budget);
        end
        tick(2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_a = 1'b1; start_b = 1'b1; init_done = 1'b1;
        tick(3);
        n_cmp++; if ({bus_a.avl_read, bus_a.avl_burstbegin, done_a, pass_a} !== 4'b0) begin n_bad++;
            $display("FAIL rst_flags: got %b, required 0000", {bus_a.avl_read, bus_a.avl_burstbegin, done_a, pass_a}); end
        n_cmp++; if (bus_a.avl_address !== '0 || bus_a.avl_burstcount !== '0) begin n_bad++;
            $display("FAIL rst_cmd: addr %0h bc %0d, required 0 0", bus_a.avl_address, bus_a.avl_burstcount); end
        n_cmp++; if (err_a !== 16'd0 || first_a !== '0 || state_a !== 3'd0) begin n_bad++;
            $display("FAIL rst_status: err %0d first %0h state %0d, required 0", err_a, first_a, state_a); end
        rst_n = 1'b1;
        tick(5);
        n_cmp++; if (state_a !== 3'd0 || state_b !== 3'd0 || bus_a.avl_read !== 1'b0) begin n_bad++;
            $display("FAIL start_through_reset: states %0d/%0d read %b, required 0/0 0", state_a, state_b, bus_a.avl_read); end
        start_a = 1'b0; start_b = 1'b0;
        tick(2);
    endtask

    task automatic test_ideal();
        int bad_bc;
        sel = 1'b0; rand_wait = 1'b0; lat = 6; gap_pct = 0; hold = 1'b0;
        corr_addr.delete(); corr_mask.delete();
        clear_stats(); pulse_start(1'b0);
        wait_done(20000, "ideal");
        bad_bc = 0;
        foreach (cmd_bc[i]) if (cmd_bc[i] != BL) bad_bc++;
        n_cmp++; if (cmd_cnt != (FW_A + BL - 1) / BL) begin n_bad++;
            $display("FAIL ideal_cmds: got %0d, required %0d", cmd_cnt, (FW_A + BL - 1) / BL); end
        n_cmp++; if (bad_cmd != 0 || bad_bc != 0) begin n_bad++;
            $display("FAIL ideal_cmd_seq: %0d bad commands, %0d non-8 bursts, required 0", bad_cmd, bad_bc); end
        n_cmp++; if (pass_a !== 1'b1 || err_a !== 16'd0) begin n_bad++;
            $display("FAIL ideal_result: pass %b err %0d, required 1 0", pass_a, err_a); end
        n_cmp++; if (done_cyc - last_rv_cyc != 2) begin n_bad++;
            $display("FAIL ideal_done_latency: got %0d cycles, required 2", done_cyc - last_rv_cyc); end
        n_cmp++; if (max_outst > MO * BL) begin n_bad++;
            $display("FAIL ideal_outstanding: got %0d words, required <= %0d", max_outst, MO * BL); end
    endtask

    task automatic test_corrupt();
        sel = 1'b0; rand_wait = 1'b0; lat = 6; gap_pct = 0; hold = 1'b0;
        corr_addr = '{32'h1000, 32'h2000};
        corr_mask = '{32'h0000_0001, 32'h0000_0100};
        clear_stats(); pulse_start(1'b0);
        wait_done(20000, "corrupt");
        n_cmp++; if (err_a !== 16'd2) begin n_bad++; $display("FAIL corrupt_count: got %0d, required 2", err_a); end
        n_cmp++; if (first_a !== AW'(32'h1000)) begin n_bad++;
            $display("FAIL corrupt_first: got %0h, required 1000", first_a); end
        n_cmp++; if (pass_a !== 1'b0 || done_a !== 1'b1) begin n_bad++;
            $display("FAIL corrupt_pass: pass %b done %b, required 0 1", pass_a, done_a); end
    endtask

    task automatic test_waitrequest();
        sel = 1'b0; rand_wait = 1'b1; lat = 6; gap_pct = 0; hold = 1'b0;
        corr_addr.delete(); corr_mask.delete();
        clear_stats(); pulse_start(1'b0);
        wait_done(30000, "waitreq");
        n_cmp++; if (proto_err != 0) begin n_bad++; $display("FAIL waitreq_stable: got %0d violations, required 0", proto_err); end
        n_cmp++; if (bb_cnt != cmd_cnt || cmd_cnt != (FW_A + BL - 1) / BL) begin n_bad++;
            $display("FAIL waitreq_burstbegin: %0d pulses for %0d commands, required %0d each", bb_cnt, cmd_cnt, (FW_A + BL - 1) / BL); end
        n_cmp++; if (pass_a !== 1'b1 || bad_cmd != 0) begin n_bad++;
            $display("FAIL waitreq_result: pass %b bad_cmd %0d, required 1 0", pass_a, bad_cmd); end
    endtask

    task automatic test_stall();
        sel = 1'b0; rand_wait = 1'b0; lat = 6; gap_pct = 0; hold = 1'b1;
        corr_addr.delete(); corr_mask.delete();
        clear_stats(); pulse_start(1'b0);
        tick(200);
        n_cmp++; if (cmd_cnt != MO || bus_a.avl_read !== 1'b0 || state_a !== 3'd1) begin n_bad++;
            $display("FAIL stall_limit: %0d bursts read %b state %0d, required %0d 0 1", cmd_cnt, bus_a.avl_read, state_a, MO); end
        n_cmp++; if (words_acc - words_ret != MO * BL) begin n_bad++;
            $display("FAIL stall_outstanding: got %0d, required %0d", words_acc - words_ret, MO * BL); end
        hold = 1'b0;
        wait_done(20000, "stall");
        n_cmp++; if (pass_a !== 1'b1 || cmd_cnt != (FW_A + BL - 1) / BL || max_outst > MO * BL) begin n_bad++;
            $display("FAIL stall_result: pass %b cmds %0d max_outst %0d, required 1 %0d <=%0d",
                pass_a, cmd_cnt, max_outst, (FW_A + BL - 1) / BL, MO * BL); end
    endtask

    task automatic test_random();
        int n, exp_first;
        int unsigned a;
        bit dup;
        sel = 1'b0; rand_wait = 1'b1; lat = $urandom_range(1, 12); gap_pct = 20; hold = 1'b0;
        corr_addr.delete(); corr_mask.delete();
        n = $urandom_range(1, 4);
        while (corr_addr.size() < n) begin
            a = $urandom_range(0, FW_A - 1);
            dup = 1'b0;
            foreach (corr_addr[i]) if (corr_addr[i] == a) dup = 1'b1;
            if (!dup) begin corr_addr.push_back(a); corr_mask.push_back(DW'(1) << $urandom_range(0, DW - 1)); end
        end
        exp_first = FW_A;
        foreach (corr_addr[i]) if (int'(corr_addr[i]) < exp_first) exp_first = int'(corr_addr[i]);
        clear_stats(); pulse_start(1'b0);
        wait_done(40000, "random");
        n_cmp++; if (err_a !== 16'(n)) begin n_bad++; $display("FAIL random_count: got %0d, required %0d", err_a, n); end
        n_cmp++; if (first_a !== AW'(exp_first)) begin n_bad++;
            $display("FAIL random_first: got %0h, required %0h", first_a, exp_first); end
        n_cmp++; if (pass_a !== 1'b0 || bad_cmd != 0 || proto_err != 0 || max_outst > MO * BL) begin n_bad++;
            $display("FAIL random_misc: pass %b bad_cmd %0d proto %0d max_outst %0d, required 0 0 0 <=%0d",
                pass_a, bad_cmd, proto_err, max_outst, MO * BL); end
    endtask

    task automatic test_small_frame();
        int exp_bc;
        sel = 1'b1; rand_wait = 1'b0; lat = 3; gap_pct = 0; hold = 1'b0;
        corr_addr.delete(); corr_mask.delete();
        init_done = 1'b0; start_b = 1'b1;
        tick(5);
        n_cmp++; if (state_b !== 3'd0 || bus_b.avl_read !== 1'b0) begin n_bad++;
            $display("FAIL no_init_start: state %0d read %b, required 0 0", state_b, bus_b.avl_read); end
        init_done = 1'b1;
        tick(5);
        n_cmp++; if (state_b !== 3'd0) begin n_bad++; $display("FAIL level_no_start: state %0d, required 0", state_b); end
        start_b = 1'b0; tick(1);
        clear_stats(); pulse_start(1'b1);
        wait_done(500, "small");
        n_cmp++; if (cmd_cnt != 3) begin n_bad++; $display("FAIL small_cmds: got %0d, required 3", cmd_cnt); end
        for (int i = 0; i < cmd_bc.size() && i < 3; i++) begin
            exp_bc = (FW_B - BL * i < BL) ? FW_B - BL * i : BL;
            n_cmp++; if (cmd_bc[i] != exp_bc || cmd_addr[i] != BL * i) begin n_bad++;
                $display("FAIL small_burst%0d: addr %0d bc %0d, required %0d %0d", i, cmd_addr[i], cmd_bc[i], BL * i, exp_bc); end
        end
        n_cmp++; if (pass_b !== 1'b1 || err_b !== 16'd0 || done_cyc - last_rv_cyc != 2) begin n_bad++;
            $display("FAIL small_result: pass %b err %0d latency %0d, required 1 0 2", pass_b, err_b, done_cyc - last_rv_cyc); end
    endtask

    task automatic test_reset_mid_drain();
        int i;
        sel = 1'b1; rand_wait = 1'b0; lat = 3; gap_pct = 0; hold = 1'b1;
        corr_addr.delete(); corr_mask.delete();
        clear_stats(); pulse_start(1'b1);
        for (i = 0; i < 100 && state_b !== 3'd2; i++) tick(1);
        n_cmp++; if (state_b !== 3'd2 || words_acc != FW_B) begin n_bad++;
            $display("FAIL drain_reached: state %0d words %0d, required 2 %0d", state_b, words_acc, FW_B); end
        hold = 1'b0;
        for (i = 0; i < 100 && words_ret < 4; i++) tick(1);
        hold = 1'b1; rst_n = 1'b0;
        tick(3);
        n_cmp++; if ({done_b, pass_b, bus_b.avl_read, bus_b.avl_burstbegin} !== 4'b0 || err_b !== 16'd0 ||
                     first_b !== '0 || state_b !== 3'd0 || bus_b.avl_address !== '0 || bus_b.avl_burstcount !== '0) begin n_bad++;
            $display("FAIL mid_reset_outputs: done %b pass %b err %0d state %0d, required all 0", done_b, pass_b, err_b, state_b); end
        rst_n = 1'b1; hold = 1'b0;
        tick(30);
        n_cmp++; if (words_ret != FW_B || state_b !== 3'd0 || err_b !== 16'd0 || done_b !== 1'b0) begin n_bad++;
            $display("FAIL late_data_ignored: returned %0d state %0d err %0d done %b, required %0d 0 0 0",
                words_ret, state_b, err_b, done_b, FW_B); end
        clear_stats(); pulse_start(1'b1);
        wait_done(500, "restart");
        n_cmp++; if (pass_b !== 1'b1 || err_b !== 16'd0) begin n_bad++;
            $display("FAIL restart_result: pass %b err %0d, required 1 0", pass_b, err_b); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        sel = 1'b0; rand_wait = 1'b0; hold = 1'b0; flush = 1'b0; lat = 6; gap_pct = 0;
        done_cyc = -1; exp_addr = 0;
        test_reset();
        test_ideal();
        test_corrupt();
        test_waitrequest();
        test_stall();
        test_random();
        test_small_frame();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
